// File: rtl/nfu_1_pipe.sv
// nfu_1_pipe: two-stage Tn x Tn signed fixed-point multiplier array with optional rounding, saturation and a saturation-event counter
// Ports: clk/rst_n (async active-low); i_valid/o_ready accept one operand set (i_image: Tn lanes,
//        i_synapse: Tn x Tn row-major, i_round_en, i_sat_en); o_valid/i_ready deliver o_results
//        (word i*Tn+j = image[i] x synapse[i*Tn+j]) with o_sat_flag; o_sat_count counts delivered
//        saturated sets, sticks at its maximum, and is cleared by i_cnt_clr.
module nfu_1_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn = 16,
  parameter int Q = 10,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [BIT_WIDTH*Tn-1:0]       i_image,
  input  logic [BIT_WIDTH*Tn*Tn-1:0]    i_synapse,
  input  logic                          i_round_en,
  input  logic                          i_sat_en,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [BIT_WIDTH*Tn*Tn-1:0]    o_results,
  output logic                          o_sat_flag,
  input  logic                          i_cnt_clr,
  output logic [CNT_W-1:0]              o_sat_count
);
  localparam int PW = 2 * BIT_WIDTH;
  localparam int NP = Tn * Tn;
  localparam logic signed [PW-1:0] MAXV = {{(BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (Q - 1);
  localparam logic signed [PW-1:0] NONE = '0;

  logic                       en;
  logic                       s1Valid;
  logic [BIT_WIDTH*Tn-1:0]    s1Image;
  logic [BIT_WIDTH*NP-1:0]    s1Synapse;
  logic                       s1Round;
  logic                       s1Sat;
  logic [BIT_WIDTH*NP-1:0]    prod;
  logic [NP-1:0]              satVec;

  // One advance enable for the whole pipe: it moves whenever the output slot is free or being taken.
  assign en = !o_valid || i_ready;
  assign o_ready = en;

  for (genvar i = 0; i < Tn; i++) begin : g_row
    for (genvar j = 0; j < Tn; j++) begin : g_col
      logic signed [BIT_WIDTH-1:0] opA, opB;
      logic signed [PW-1:0]        prodFull, prodBias, prodShift;
      logic                        hi, lo;
      assign opA = s1Image[i*BIT_WIDTH +: BIT_WIDTH];
      assign opB = s1Synapse[(i*Tn+j)*BIT_WIDTH +: BIT_WIDTH];
      assign prodFull = PW'(opA) * PW'(opB);
      // The bias cannot overflow: the largest product magnitude is 2^(PW-2).
      assign prodBias = prodFull + (s1Round ? HALF : NONE);
      assign prodShift = prodBias >>> Q;
      assign hi = prodShift > MAXV;
      assign lo = prodShift < MINV;
      assign satVec[i*Tn+j] = s1Sat && (hi || lo);
      assign prod[(i*Tn+j)*BIT_WIDTH +: BIT_WIDTH] = (s1Sat && hi) ? MAXV[BIT_WIDTH-1:0] :
                                                    (s1Sat && lo) ? MINV[BIT_WIDTH-1:0] :
                                                    prodShift[BIT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid    <= 1'b0;
      s1Image    <= '0;
      s1Synapse  <= '0;
      s1Round    <= 1'b0;
      s1Sat      <= 1'b0;
      o_valid    <= 1'b0;
      o_results  <= '0;
      o_sat_flag <= 1'b0;
    end else if (en) begin
      s1Valid    <= i_valid;
      s1Image    <= i_image;
      s1Synapse  <= i_synapse;
      s1Round    <= i_round_en;
      s1Sat      <= i_sat_en;
      o_valid    <= s1Valid;
      o_results  <= prod;
      o_sat_flag <= s1Valid && (|satVec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_sat_count <= '0;
    else if (i_cnt_clr)
      o_sat_count <= '0;
    else if (o_valid && i_ready && o_sat_flag && o_sat_count != '1)
      o_sat_count <= o_sat_count + 1'b1;
  end
endmodule

// File: tb/tb_nfu_1_pipe.sv
// tb_nfu_1_pipe: self-checking bench for nfu_1_pipe (BIT_WIDTH=16, Tn=2, Q=10, CNT_W=2)
module tb_nfu_1_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, i_round_en, i_sat_en, o_valid, i_ready, o_sat_flag, i_cnt_clr;
  logic [31:0] i_image;
  logic [63:0] i_synapse, o_results;
  logic [1:0]  o_sat_count;

  typedef struct {logic [63:0] res; logic flag;} exp_t;
  typedef struct {logic [31:0] img; logic [63:0] syn; logic rnd, sat; logic [63:0] res; logic flag; logic [1:0] cnt;} vec_t;

  exp_t expQ[$];
  vec_t tbl[7];
  int   tests = 0, failed = 0, modelCnt = 0, delivered = 0, accepted = 0;

  nfu_1_pipe #(.BIT_WIDTH(16), .Tn(2), .Q(10), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_image(i_image), .i_synapse(i_synapse), .i_round_en(i_round_en), .i_sat_en(i_sat_en),
    .o_valid(o_valid), .i_ready(i_ready), .o_results(o_results), .o_sat_flag(o_sat_flag),
    .i_cnt_clr(i_cnt_clr), .o_sat_count(o_sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: exact integer product, optional +half, floor divide by 2^Q, then clamp or wrap.
  function automatic void model(input logic [31:0] img, input logic [63:0] syn, input logic rnd, input logic sat,
                                output logic [63:0] res, output logic flag);
    shortint a, b;
    longint  p;
    flag = 1'b0;
    res = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        a = img[i*16 +: 16];
        b = syn[(i*2+j)*16 +: 16];
        p = longint'(a) * longint'(b);
        if (rnd) p = p + 512;
        p = p >>> 10;
        if (sat && p > 32767) begin p = 32767; flag = 1'b1; end
        else if (sat && p < -32768) begin p = -32768; flag = 1'b1; end
        res[(i*2+j)*16 +: 16] = p[15:0];
      end
  endfunction

  task automatic tick();
    logic inHs, outHs, hold;
    logic [63:0] pr;
    exp_t e;
    e = '{res: '0, flag: 1'b0};
    #1;
    inHs = i_valid && o_ready;
    outHs = o_valid && i_ready;
    hold = o_valid && !i_ready;
    pr = o_results;
    if (outHs) begin
      delivered++;
      if (expQ.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_output: got %h required no output", o_results);
      end else begin
        e = expQ.pop_front();
        chk("sb_res", o_results, e.res);
        chk("sb_flag", 64'(o_sat_flag), 64'(e.flag));
      end
    end
    if (i_cnt_clr) modelCnt = 0;
    else if (outHs && e.flag && modelCnt < 3) modelCnt++;
    if (inHs) begin
      model(i_image, i_synapse, i_round_en, i_sat_en, e.res, e.flag);
      expQ.push_back(e);
      accepted++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("cnt", 64'(o_sat_count), 64'(modelCnt));
    if (hold) begin
      chk("hold_valid", 64'(o_valid), 64'(1));
      chk("hold_res", o_results, pr);
    end
  endtask

  task automatic drive(input logic v, input vec_t t);
    i_valid = v;
    i_image = t.img;
    i_synapse = t.syn;
    i_round_en = t.rnd;
    i_sat_en = t.sat;
  endtask

  initial begin
    int a0, d0;
    tbl[0] = '{32'h0400_0400, 64'h0600_0600_0600_0600, 1'b1, 1'b1, 64'h0600_0600_0600_0600, 1'b0, 2'd0};
    tbl[1] = '{32'h0001_0001, 64'h0200_0200_0200_0200, 1'b0, 1'b1, 64'h0000_0000_0000_0000, 1'b0, 2'd0};
    tbl[2] = '{32'h0001_0001, 64'h0200_0200_0200_0200, 1'b1, 1'b1, 64'h0001_0001_0001_0001, 1'b0, 2'd0};
    tbl[3] = '{32'h8000_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b0, 1'b1, 64'h8000_8000_7FFF_7FFF, 1'b1, 2'd1};
    tbl[4] = '{32'h8000_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b0, 1'b0, 64'h0020_0020_FFC0_FFC0, 1'b0, 2'd1};
    tbl[5] = '{32'h0200_FC00, 64'hFFFF_0001_F800_0C00, 1'b0, 1'b1, 64'hFFFF_0000_0800_F400, 1'b0, 2'd1};
    tbl[6] = '{32'h0200_FC00, 64'hFFFF_0001_F800_0C00, 1'b1, 1'b1, 64'h0000_0001_0800_F400, 1'b0, 2'd1};

    rst_n = 1'b0;
    i_valid = 1'b0; i_ready = 1'b0; i_cnt_clr = 1'b0; i_round_en = 1'b0; i_sat_en = 1'b0;
    i_image = '0; i_synapse = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_o_ready", 64'(o_ready), 64'(1));
    chk("rst_results", o_results, 64'h0);
    chk("rst_flag", 64'(o_sat_flag), 64'(0));
    chk("rst_count", 64'(o_sat_count), 64'(0));
    rst_n = 1'b1;
    i_ready = 1'b1;

    foreach (tbl[k]) begin
      drive(1'b1, tbl[k]);
      tick();
      chk("tbl_latency", 64'(o_valid), 64'(0));
      i_valid = 1'b0;
      tick();
      chk("tbl_valid", 64'(o_valid), 64'(1));
      chk("tbl_res", o_results, tbl[k].res);
      chk("tbl_flag", 64'(o_sat_flag), 64'(tbl[k].flag));
      tick();
      chk("tbl_cnt", 64'(o_sat_count), 64'(tbl[k].cnt));
    end

    drive(1'b1, tbl[3]);
    repeat (5) tick();
    i_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_stick", 64'(o_sat_count), 64'(3));
    drive(1'b1, tbl[3]);
    tick();
    i_valid = 1'b0;
    tick();
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    chk("cnt_clr_prio", 64'(o_sat_count), 64'(0));

    a0 = accepted;
    d0 = delivered;
    for (int c = 0; c < 20 && delivered - d0 < 4; c++) begin
      i_valid = (accepted - a0) < 4;
      i_image = $urandom;
      i_synapse = {$urandom, $urandom};
      i_round_en = 1'b0;
      i_sat_en = 1'b1;
      i_ready = !(c >= 2 && c < 5);
      #1;
      if (c >= 2 && c < 5) chk("stall_ready", 64'(o_ready), 64'(0));
      tick();
    end
    chk("bp_delivered", 64'(delivered - d0), 64'(4));
    chk("bp_queue", 64'(expQ.size()), 64'(0));

    i_ready = 1'b1;
    drive(1'b1, tbl[0]);
    tick();
    drive(1'b1, tbl[3]);
    tick();
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'(0));
    chk("mid_rst_results", o_results, 64'h0);
    chk("mid_rst_flag", 64'(o_sat_flag), 64'(0));
    chk("mid_rst_count", 64'(o_sat_count), 64'(0));
    chk("mid_rst_ready", 64'(o_ready), 64'(1));
    expQ.delete();
    modelCnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, tbl[5]);
    tick();
    chk("post_rst_empty", 64'(o_valid), 64'(0));
    i_valid = 1'b0;
    tick();
    chk("post_rst_valid", 64'(o_valid), 64'(1));
    chk("post_rst_res", o_results, tbl[5].res);
    tick();

    for (int c = 0; c < 300; c++) begin
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 3) != 0;
      i_cnt_clr = $urandom_range(0, 19) == 0;
      i_round_en = $urandom_range(0, 1) == 1;
      i_sat_en = $urandom_range(0, 3) != 0;
      i_image = $urandom_range(0, 1) == 1 ? $urandom : {16'($urandom_range(0, 2047)), 16'($urandom_range(0, 2047))};
      i_synapse = {$urandom, $urandom};
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_cnt_clr = 1'b0;
    repeat (4) tick();
    chk("rand_drain", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
